external_link_scheduler: RTL and testbench

EXTERNAL_LINK_SCHEDULER -- requirements
Module: external_link_scheduler

---
 rtl/external_link_scheduler_pkg.sv | 19 +
 rtl/external_link_scheduler_rr_arbiter.sv | 38 +++
 rtl/external_link_scheduler.sv | 167 ++++++++++++++++
 tb/tb_external_link_scheduler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/external_link_scheduler_pkg.sv
// Shared decoder-stage encoding and scheduler-local types for the external link scheduler.
package external_link_scheduler_pkg;

    localparam int unsigned STAGE_WIDTH = 3;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_SENDING = 3'd2;
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROWTH              = 3'd3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd4;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd5;
    localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd6;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/external_link_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_LINKS = 8,
    parameter int unsigned IDX_W     = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1
) (
    input  logic [NUM_LINKS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_LINKS-1:0] grant_o,
    output logic [IDX_W-1:0]     grant_idx_o,
    output logic                 grant_valid_o
);

    localparam int unsigned SEL_W = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;

    int unsigned        idx;
    logic [SEL_W-1:0]   sel;

    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        idx           = 0;
        sel           = '0;
        for (int unsigned i = 0; i < NUM_LINKS; i++) begin
            idx = 32'(ptr_i) + i;
            if (idx >= NUM_LINKS) begin
                idx = idx - NUM_LINKS;
            end
            sel = SEL_W'(idx);
            if (!grant_valid_o && req_i[sel]) begin
                grant_valid_o = 1'b1;
                grant_o[sel]  = 1'b1;
                grant_idx_o   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/external_link_scheduler.sv
// Multiplexes NUM_LINKS link FIFOs onto one tagged inter-FPGA channel and
// demultiplexes the inbound channel back to per-link strobes.
module external_link_scheduler
    import external_link_scheduler_pkg::*;
#(
    parameter int unsigned NUM_LINKS      = 8,
    parameter int unsigned FIFO_DATA_SIZE = 10,
    parameter int unsigned IDX_W          = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [STAGE_WIDTH-1:0]              global_stage,
    input  logic [NUM_LINKS*FIFO_DATA_SIZE-1:0] link_out_data,
    input  logic [NUM_LINKS-1:0]                link_out_valid,
    output logic [NUM_LINKS-1:0]                link_out_ready,
    output logic [NUM_LINKS*FIFO_DATA_SIZE-1:0] link_in_data,
    output logic [NUM_LINKS-1:0]                link_in_valid,
    output logic [IDX_W+FIFO_DATA_SIZE-1:0]     chan_out_data,
    output logic                                chan_out_valid,
    input  logic                                chan_out_ready,
    input  logic [IDX_W+FIFO_DATA_SIZE-1:0]     chan_in_data,
    input  logic                                chan_in_valid,
    output logic                                chan_in_ready,
    output logic                                busy,
    output logic [15:0]                         msg_count,
    output logic                                bad_index
);

    localparam int unsigned CW = IDX_W + FIFO_DATA_SIZE;

    logic [STAGE_WIDTH-1:0]              stage_q;
    logic                                stage_entry;

    slot_state_t                         slot_q, slot_d;
    logic                                accept, take, drain;

    logic [NUM_LINKS-1:0]                grant;
    logic [IDX_W-1:0]                    grant_idx;
    logic                                grant_valid;
    logic [FIFO_DATA_SIZE-1:0]           grant_pay;

    logic [CW-1:0]                       chan_out_data_q, chan_out_data_d;
    logic [IDX_W-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [15:0]                         msg_count_q, msg_count_d;

    logic [IDX_W-1:0]                    in_idx;
    logic [FIFO_DATA_SIZE-1:0]           in_pay;
    logic                                in_ok;
    logic [NUM_LINKS-1:0]                link_in_valid_q, link_in_valid_d;
    logic [NUM_LINKS*FIFO_DATA_SIZE-1:0] link_in_data_q, link_in_data_d;
    logic                                bad_index_q, bad_index_d;

    // First cycle of measurement loading flushes the outbound path.
    assign stage_entry = (global_stage == STAGE_MEASUREMENT_LOADING) &&
                         (stage_q != STAGE_MEASUREMENT_LOADING);

    rr_arbiter #(
        .NUM_LINKS (NUM_LINKS),
        .IDX_W     (IDX_W)
    ) u_rr_arbiter (
        .req_i         (link_out_valid),
        .ptr_i         (rr_ptr_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= SLOT_EMPTY;
        end else begin
            slot_q <= slot_d;
        end
    end

    always_comb begin
        drain  = (slot_q == SLOT_FULL) && chan_out_ready;
        accept = !reset && !stage_entry && ((slot_q == SLOT_EMPTY) || chan_out_ready);
        take   = accept && grant_valid;
        slot_d = slot_q;
        if (stage_entry) begin
            slot_d = SLOT_EMPTY;
        end else if (take) begin
            slot_d = SLOT_FULL;
        end else if (drain) begin
            slot_d = SLOT_EMPTY;
        end
    end

    always_comb begin
        chan_out_valid = (slot_q == SLOT_FULL);
        link_out_ready = accept ? grant : '0;
    end

    always_comb begin
        grant_pay = '0;
        for (int unsigned i = 0; i < NUM_LINKS; i++) begin
            if (grant[i]) begin
                grant_pay = link_out_data[i*FIFO_DATA_SIZE +: FIFO_DATA_SIZE];
            end
        end
    end

    always_comb begin
        chan_out_data_d = chan_out_data_q;
        rr_ptr_d        = rr_ptr_q;
        msg_count_d     = msg_count_q;
        if (stage_entry) begin
            chan_out_data_d = '0;
            rr_ptr_d        = '0;
            msg_count_d     = '0;
        end else begin
            if (take) begin
                chan_out_data_d = {grant_idx, grant_pay};
                rr_ptr_d = (32'(grant_idx) == NUM_LINKS - 1) ? '0 : grant_idx + IDX_W'(1);
            end
            if (drain && (msg_count_q != '1)) begin
                msg_count_d = msg_count_q + 16'd1;
            end
        end
    end

    assign in_idx = chan_in_data[CW-1 -: IDX_W];
    assign in_pay = chan_in_data[FIFO_DATA_SIZE-1:0];
    assign in_ok  = chan_in_valid && (32'(in_idx) < NUM_LINKS);

    always_comb begin
        link_in_valid_d = '0;
        link_in_data_d  = link_in_data_q;
        bad_index_d     = bad_index_q || (chan_in_valid && !in_ok);
        for (int unsigned i = 0; i < NUM_LINKS; i++) begin
            if (in_ok && (32'(in_idx) == i)) begin
                link_in_valid_d[i] = 1'b1;
                link_in_data_d[i*FIFO_DATA_SIZE +: FIFO_DATA_SIZE] = in_pay;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q         <= STAGE_IDLE;
            chan_out_data_q <= '0;
            rr_ptr_q        <= '0;
            msg_count_q     <= '0;
            link_in_valid_q <= '0;
            link_in_data_q  <= '0;
            bad_index_q     <= 1'b0;
        end else begin
            stage_q         <= global_stage;
            chan_out_data_q <= chan_out_data_d;
            rr_ptr_q        <= rr_ptr_d;
            msg_count_q     <= msg_count_d;
            link_in_valid_q <= link_in_valid_d;
            link_in_data_q  <= link_in_data_d;
            bad_index_q     <= bad_index_d;
        end
    end

    assign chan_out_data = chan_out_data_q;
    assign msg_count     = msg_count_q;
    assign link_in_valid = link_in_valid_q;
    assign link_in_data  = link_in_data_q;
    assign bad_index     = bad_index_q;
    assign chan_in_ready = 1'b1;
    assign busy          = chan_out_valid || (|link_out_valid);

endmodule

// File: tb/tb_external_link_scheduler.sv
// Directed bench for external_link_scheduler with 8 links and a 4-bit index tag.
module tb_external_link_scheduler;
    import external_link_scheduler_pkg::*;

    localparam int unsigned NL = 8;
    localparam int unsigned FD = 10;
    localparam int unsigned IW = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [STAGE_WIDTH-1:0] global_stage;
    logic [NL*FD-1:0]       link_out_data;
    logic [NL-1:0]          link_out_valid;
    logic [NL-1:0]          link_out_ready;
    logic [NL*FD-1:0]       link_in_data;
    logic [NL-1:0]          link_in_valid;
    logic [IW+FD-1:0]       chan_out_data;
    logic                   chan_out_valid;
    logic                   chan_out_ready;
    logic [IW+FD-1:0]       chan_in_data;
    logic                   chan_in_valid;
    logic                   chan_in_ready;
    logic                   busy;
    logic [15:0]            msg_count;
    logic                   bad_index;

    int n_run  = 0;
    int n_fail = 0;
    logic [NL*FD-1:0] exp_in;

    external_link_scheduler #(
        .NUM_LINKS      (NL),
        .FIFO_DATA_SIZE (FD),
        .IDX_W          (IW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .global_stage   (global_stage),
        .link_out_data  (link_out_data),
        .link_out_valid (link_out_valid),
        .link_out_ready (link_out_ready),
        .link_in_data   (link_in_data),
        .link_in_valid  (link_in_valid),
        .chan_out_data  (chan_out_data),
        .chan_out_valid (chan_out_valid),
        .chan_out_ready (chan_out_ready),
        .chan_in_data   (chan_in_data),
        .chan_in_valid  (chan_in_valid),
        .chan_in_ready  (chan_in_ready),
        .busy           (busy),
        .msg_count      (msg_count),
        .bad_index      (bad_index)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [NL*FD-1:0] obs, input logic [NL*FD-1:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        global_stage   = STAGE_IDLE;
        link_out_valid = 8'h04;
        chan_out_ready = 1'b0;
        chan_in_valid  = 1'b0;
        chan_in_data   = '0;
        // Link i payload = i*37+5: 0->005 2->04F 3->074 4->099 5->0BE 6->0E3
        for (int i = 0; i < NL; i++) link_out_data[i*FD +: FD] = 10'(i*37 + 5);

        tick(); tick(); #1;
        chk("rst_ready",     80'(link_out_ready), 80'h0);
        chk("rst_cvalid",    80'(chan_out_valid), 80'h0);
        chk("rst_cdata",     80'(chan_out_data),  80'h0);
        chk("rst_msgcount",  80'(msg_count),      80'h0);
        chk("rst_badidx",    80'(bad_index),      80'h0);
        chk("rst_invalid",   80'(link_in_valid),  80'h0);
        chk("rst_indata",    link_in_data,        80'h0);
        chk("rst_busy",      80'(busy),           80'h1);
        chk("chan_in_ready", 80'(chan_in_ready),  80'h1);

        // Single grant to link 2
        tick();
        reset = 1'b0; link_out_valid = 8'h04; chan_out_ready = 1'b1; #1;
        chk("l2_ready", 80'(link_out_ready), 80'h04);
        tick();
        link_out_valid = 8'h00; #1;
        chk("l2_cvalid",  80'(chan_out_valid), 80'h1);
        chk("l2_cdata",   80'(chan_out_data),  80'({4'd2, 10'h04F}));
        chk("l2_msg0",    80'(msg_count),      80'h0);
        tick(); #1;
        chk("l2_drained", 80'(chan_out_valid), 80'h0);
        chk("l2_msg1",    80'(msg_count),      80'h1);
        chk("l2_busy0",   80'(busy),           80'h0);

        // Backpressure: rr_ptr=3, link 4 granted into empty slot, then stall 4 cycles
        link_out_valid = 8'h10; chan_out_ready = 1'b0; #1;
        chk("bp_first_grant", 80'(link_out_ready), 80'h10);
        tick();
        link_out_valid = 8'h50; #1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_ready0", 80'(link_out_ready), 80'h0);
            chk("bp_cdata",  80'(chan_out_data),  80'({4'd4, 10'h099}));
            chk("bp_cvalid", 80'(chan_out_valid), 80'h1);
            tick(); #1;
        end
        chan_out_ready = 1'b1; #1;
        chk("bp_release_grant", 80'(link_out_ready), 80'h40);
        tick();
        link_out_valid = 8'h00; #1;
        chk("bp_cdata6", 80'(chan_out_data), 80'({4'd6, 10'h0E3}));
        chk("bp_msg2",   80'(msg_count),     80'd2);
        tick(); #1;
        chk("bp_empty",  80'(chan_out_valid), 80'h0);
        chk("bp_msg3",   80'(msg_count),      80'd3);

        // Inbound demux and bad index
        chan_in_valid = 1'b1; chan_in_data = {4'd6, 10'h155};
        tick(); #1;
        exp_in = 80'h155 << 60;
        chk("in6_valid", 80'(link_in_valid), 80'h40);
        chk("in6_data",  link_in_data,       exp_in);
        chk("in6_bad",   80'(bad_index),     80'h0);
        chan_in_data = {4'd1, 10'h0AA};
        tick(); #1;
        exp_in = exp_in | (80'h0AA << 10);
        chk("in1_valid", 80'(link_in_valid), 80'h02);
        chk("in1_data",  link_in_data,       exp_in);
        chan_in_data = {4'd9, 10'h3FF};
        tick(); #1;
        chk("in9_valid", 80'(link_in_valid), 80'h0);
        chk("in9_bad",   80'(bad_index),     80'h1);
        chk("in9_data",  link_in_data,       exp_in);
        chan_in_valid = 1'b0;
        tick(); #1;
        chk("bad_sticky", 80'(bad_index),     80'h1);
        chk("in_idle",    80'(link_in_valid), 80'h0);

        // Stage entry flush: rr_ptr=7 so link 2 fills the slot
        link_out_valid = 8'h04; chan_out_ready = 1'b0; #1;
        chk("ml_fill_grant", 80'(link_out_ready), 80'h04);
        tick();
        link_out_valid = 8'h01; chan_out_ready = 1'b1; global_stage = STAGE_MEASUREMENT_LOADING; #1;
        chk("ml_no_grant", 80'(link_out_ready), 80'h0);
        chk("ml_full",     80'(chan_out_valid), 80'h1);
        tick();
        link_out_valid = 8'h00; #1;
        chk("ml_empty", 80'(chan_out_valid), 80'h0);
        chk("ml_msg0",  80'(msg_count),      80'h0);
        chk("ml_busy0", 80'(busy),           80'h0);

        // Round robin over links 0,3,5 starting from rr_ptr=0
        link_out_valid = 8'h29; #1;
        chk("rr_g0", 80'(link_out_ready), 80'h01);
        tick(); #1;
        chk("rr_d0", 80'(chan_out_data),  80'({4'd0, 10'h005}));
        chk("rr_g3", 80'(link_out_ready), 80'h08);
        tick(); #1;
        chk("rr_d3", 80'(chan_out_data),  80'({4'd3, 10'h074}));
        chk("rr_g5", 80'(link_out_ready), 80'h20);
        tick(); #1;
        chk("rr_d5",  80'(chan_out_data),  80'({4'd5, 10'h0BE}));
        chk("rr_g0b", 80'(link_out_ready), 80'h01);
        tick();
        link_out_valid = 8'h00; #1;
        chk("rr_d0b",  80'(chan_out_data), 80'({4'd0, 10'h005}));
        chk("rr_msg3", 80'(msg_count),     80'd3);
        tick(); #1;
        chk("rr_empty", 80'(chan_out_valid), 80'h0);
        chk("rr_msg4",  80'(msg_count),      80'd4);

        // Reset mid-transfer: rr_ptr=1 so link 3 fills the slot
        link_out_valid = 8'h08; chan_out_ready = 1'b0; #1;
        chk("mr_grant", 80'(link_out_ready), 80'h08);
        tick();
        reset = 1'b1; #1;
        chk("mr_ready0", 80'(link_out_ready), 80'h0);
        chk("mr_full",   80'(chan_out_valid), 80'h1);
        tick(); #1;
        chk("mr_cvalid", 80'(chan_out_valid), 80'h0);
        chk("mr_cdata",  80'(chan_out_data),  80'h0);
        chk("mr_bad",    80'(bad_index),      80'h0);
        chk("mr_msg",    80'(msg_count),      80'h0);
        chk("mr_indata", link_in_data,        80'h0);
        reset = 1'b0; link_out_valid = 8'h00;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
